// File: rtl/counter_rf_access_bridge.sv
// Request/response front-end for the counter register file.
// Turns one valid/ready request into a single-cycle read_en/write_en strobe,
// waits for access_complete (or a timeout), then presents one response.
module counter_rf_access_bridge #(
    parameter int ADDR_WIDTH     = 1,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  res_n,
    // request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // response channel
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_error,
    // register file side
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read_en,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  invalid_address,
    input  logic                  access_complete
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ADDR    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               out_of_reset;
    logic               is_write;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               accept;
    logic               complete;
    logic               timeout_hit;

    assign accept      = req_valid && req_ready;
    // access_complete only means something while an access is in flight
    assign complete    = ((state == S_ISSUE) || (state == S_WAIT)) && access_complete;
    // completion in the same cycle takes priority over the timeout
    assign timeout_hit = (state == S_WAIT) && !access_complete &&
                         (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // req_ready stays low until the first clock edge after reset release
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) out_of_reset <= 1'b0;
        else        out_of_reset <= 1'b1;
    end

    // state register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = access_complete ? S_RESP : S_WAIT;
            S_WAIT:  if (complete || timeout_hit) state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // state-decoded outputs; strobes exist only in ISSUE so they can never overlap
    always_comb begin
        req_ready  = (state == S_IDLE) && out_of_reset;
        read_en    = (state == S_ISSUE) && !is_write;
        write_en   = (state == S_ISSUE) && is_write;
        resp_valid = (state == S_RESP);
    end

    // request capture; address/write_data hold through ISSUE and WAIT
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            address    <= '0;
            write_data <= '0;
            is_write   <= 1'b0;
        end else if (accept) begin
            address    <= req_addr;
            write_data <= req_wdata;
            is_write   <= req_write;
        end
    end

    // timeout counter: cleared on entering WAIT, counts cycles without completion
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            tmo_cnt <= '0;
        end else if (state == S_ISSUE) begin
            tmo_cnt <= '0;
        end else if ((state == S_WAIT) && !access_complete) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // response capture; held unchanged for the whole RESP phase
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            resp_rdata <= '0;
            resp_error <= ERR_OK;
        end else if (complete) begin
            resp_error <= invalid_address ? ERR_ADDR : ERR_OK;
            resp_rdata <= (!is_write && !invalid_address) ? read_data : '0;
        end else if (timeout_hit) begin
            resp_error <= ERR_TIMEOUT;
            resp_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_counter_rf_access_bridge.sv
// Directed bench for counter_rf_access_bridge: a small register-file model
// answers strobes, a scoreboard queue holds expected responses and a monitor
// pops/compares whenever a response handshake is seen.
module tb_counter_rf_access_bridge;

    localparam int AW = 1;
    localparam int DW = 64;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [DW-1:0] resp_rdata;
    logic [1:0]    resp_error;
    logic [AW-1:0] address;
    logic          read_en;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data = '0;
    logic          invalid_address = 1'b0;
    logic          access_complete = 1'b0;

    counter_rf_access_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .res_n(res_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .address(address), .read_en(read_en), .write_en(write_en),
        .write_data(write_data), .read_data(read_data),
        .invalid_address(invalid_address), .access_complete(access_complete)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic [1:0]    err;
    } resp_t;

    resp_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    n_resp = 0;
    int    rd_pulses = 0;
    int    wr_pulses = 0;
    int    strobe_cyc = 0;
    logic [DW-1:0] last_wdata = '0;
    logic          prev_strobe = 1'b0;

    // register-file model controls
    int            rf_delay = 0;
    logic          rf_hang = 1'b0;
    logic          force_ac = 1'b0;
    logic          rf_pend = 1'b0;
    int            rf_cnt = 0;
    logic [AW-1:0] rf_a = '0;
    logic          rf_w = 1'b0;
    logic [DW-1:0] rf_d = '0;
    logic [DW-1:0] mem0 = '0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // register file: only address 0 exists; completes rf_delay cycles after the strobe
    always @(posedge clk) begin
        #2;
        access_complete = force_ac;
        invalid_address = 1'b0;
        read_data       = '0;
        if (!res_n) begin
            rf_pend = 1'b0;
        end else begin
            if (!rf_pend && (read_en || write_en)) begin
                rf_pend = 1'b1;
                rf_cnt  = rf_delay;
                rf_a    = address;
                rf_w    = write_en;
                rf_d    = write_data;
            end
            if (rf_pend && !rf_hang) begin
                if (rf_cnt == 0) begin
                    access_complete = 1'b1;
                    invalid_address = (rf_a != 0);
                    if (!invalid_address) begin
                        if (rf_w) mem0 = rf_d;
                        else      read_data = mem0;
                    end
                    rf_pend = 1'b0;
                end else begin
                    rf_cnt--;
                end
            end
        end
    end

    // strobe watcher: exclusive, single-cycle pulses
    always @(negedge clk) begin
        if (read_en || write_en) begin
            strobe_cyc = cyc;
            if (write_en) begin wr_pulses++; last_wdata = write_data; end
            if (read_en)  rd_pulses++;
            chk("strobe_exclusive", {63'd0, read_en && write_en}, 64'd0);
            chk("strobe_single_cycle", {63'd0, prev_strobe}, 64'd0);
        end
        prev_strobe = read_en || write_en;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 64'd1, 64'd0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_error", {62'd0, resp_error}, {62'd0, e.err});
            end
        end
    end

    // present a request (caller is at posedge+1) and hold until accepted
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic push, input logic [DW-1:0] er, input logic [1:0] ee);
        logic rdy;
        resp_t e;
        if (push) begin
            e.rdata = er;
            e.err   = ee;
            exp_q.push_back(e);
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk) rdy = req_ready;
            @(posedge clk); #1;
            if (rdy) return;
        end
        chk("req_accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp_valid(input string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (resp_valid) return;
        end
        chk(nm, 64'd0, 64'd1);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) return;
        end
        chk(nm, exp_q.size(), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},  {63'd0, req_ready}, 64'd0);
        chk({tag, "_read_en"},    {63'd0, read_en}, 64'd0);
        chk({tag, "_write_en"},   {63'd0, write_en}, 64'd0);
        chk({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
        chk({tag, "_resp_error"}, {62'd0, resp_error}, 64'd0);
        chk({tag, "_address"},    {63'd0, address}, 64'd0);
        chk({tag, "_write_data"}, write_data, 64'd0);
    endtask

    initial begin
        int base_w;
        int base_r;
        int base_n;
        int lat;

        // reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        res_n = 1'b1;
        #1;
        chk("ready_before_first_clk", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        chk("ready_after_first_clk", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;

        // write 400 to addr 0, RF completes during ISSUE
        base_w = wr_pulses;
        send(1'b1, 1'b0, 64'd400, 1'b1, 64'd0, 2'b00);
        idle_req();
        wait_resp_valid("write_resp_wait");
        lat = cyc - strobe_cyc;
        chk("write_min_latency", lat, 64'd1);
        drain("write_drain");
        chk("write_pulses", wr_pulses - base_w, 64'd1);
        chk("write_data", last_wdata, 64'd400);

        // read back addr 0
        @(posedge clk); #1;
        base_r = rd_pulses;
        send(1'b0, 1'b0, 64'd0, 1'b1, 64'd400, 2'b00);
        idle_req();
        drain("read_drain");
        chk("read_pulses", rd_pulses - base_r, 64'd1);

        // invalid address, completes after 2 WAIT cycles
        @(posedge clk); #1;
        rf_delay = 2;
        send(1'b0, 1'b1, 64'd0, 1'b1, 64'd0, 2'b01);
        idle_req();
        drain("invalid_drain");
        rf_delay = 0;

        // backpressure: response held 5 cycles
        @(posedge clk); #1;
        resp_ready = 1'b0;
        send(1'b0, 1'b0, 64'd0, 1'b1, 64'd400, 2'b00);
        idle_req();
        wait_resp_valid("bp_resp_wait");
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_resp_rdata", resp_rdata, 64'd400);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        drain("bp_drain");

        // timeout: RF never completes; response 17 cycles after ISSUE
        @(posedge clk); #1;
        rf_hang    = 1'b1;
        resp_ready = 1'b0;
        send(1'b0, 1'b0, 64'd0, 1'b1, 64'd0, 2'b10);
        idle_req();
        wait_resp_valid("tmo_resp_wait");
        lat = cyc - strobe_cyc;
        chk("tmo_latency", lat, 64'd17);
        // late completion while in RESP is ignored
        @(posedge clk); #1;
        force_ac = 1'b1;
        @(posedge clk); #1;
        force_ac = 1'b0;
        @(negedge clk);
        chk("late_ac_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("late_ac_resp_error", {62'd0, resp_error}, 64'd2);
        chk("late_ac_resp_rdata", resp_rdata, 64'd0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        drain("tmo_drain");
        // late completion while IDLE is ignored
        base_n = n_resp;
        @(posedge clk); #1;
        force_ac = 1'b1;
        @(posedge clk); #1;
        force_ac = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_ac_no_resp", n_resp - base_n, 64'd0);
        chk("idle_ac_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        rf_hang = 1'b0;
        rf_pend = 1'b0;

        // 10 back-to-back requests, alternating write/read on addr 0
        base_n = n_resp;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) send(1'b1, 1'b0, 64'(100 + i), 1'b1, 64'd0, 2'b00);
            else            send(1'b0, 1'b0, 64'd0, 1'b1, 64'(100 + i - 1), 2'b00);
        end
        idle_req();
        drain("b2b_drain");
        chk("b2b_count", n_resp - base_n, 64'd10);

        // reset during WAIT drops the access
        @(posedge clk); #1;
        rf_delay = 5;
        send(1'b1, 1'b1, 64'd77, 1'b0, 64'd0, 2'b00);
        idle_req();
        @(negedge clk);
        chk("pre_reset_address", {63'd0, address}, 64'd1);
        chk("pre_reset_wdata", write_data, 64'd77);
        @(posedge clk); #3;
        res_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;
        rf_delay = 0;
        base_n = n_resp;
        @(negedge clk);
        chk("post_reset_req_ready", {63'd0, req_ready}, 64'd1);
        repeat (8) @(negedge clk);
        chk("post_reset_no_resp", n_resp - base_n, 64'd0);
        chk("post_reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("scoreboard_empty", exp_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
